// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter driven by strobed commands from the ctrl-code decoder.
// Optional LSB-first support is enabled by defining SPI_LSBFIRST_EN.
module spi_byte_engine #(
    parameter int              DIVW      = 4,
    parameter logic [DIVW-1:0] DIV_RESET = '0
) (
    input  logic       CLKx4,
    input  logic       nRESET,
    input  logic       nSTB,
    input  logic [1:0] CMD,
    input  logic [7:0] DIN,
    input  logic [2:0] MISO,
    output logic       MOSI,
    output logic       SCK,
    output logic [1:0] nSS,
    output logic [7:0] DOUT,
    output logic       BUSY,
    output logic       ERR
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [1:0]      C_NOP = 2'b00;
    localparam logic [1:0]      C_SEL = 2'b01;
    localparam logic [1:0]      C_XFR = 2'b10;
    localparam logic [1:0]      C_CFG = 2'b11;
    localparam logic [DIVW-1:0] ONE   = {{(DIVW-1){1'b0}}, 1'b1};

    logic            stb_s1, stb_s2, stb_d, ev_q;
    logic [1:0]      cmd_q;
    logic [7:0]      din_q;
    logic            cmd_ev, misox;

    state_t          state, state_n;
    logic [DIVW-1:0] div_r, div_n, divcnt, divcnt_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shreg, shreg_n, dout_n;
    logic            rx_bit, rx_n;
    logic            sck_n, mosi_n, busy_n, err_n;
    logic [1:0]      nss_n;
    logic            lsbf;
`ifdef SPI_LSBFIRST_EN
    logic            lsbf_n;
`else
    assign lsbf = 1'b0;
`endif

    // Falling edge of the synchronized strobe; command fields are captured with it.
    assign cmd_ev = stb_d & ~stb_s2;
    assign misox  = (MISO[0] & ~nSS[0]) | (MISO[1] & ~nSS[1]) | (MISO[2] & nSS[0] & nSS[1]);

    always_ff @(posedge CLKx4 or negedge nRESET) begin
        if (!nRESET) begin
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
            stb_d  <= 1'b1;
            ev_q   <= 1'b0;
            cmd_q  <= C_NOP;
            din_q  <= 8'h00;
        end else begin
            stb_s1 <= nSTB;
            stb_s2 <= stb_s1;
            stb_d  <= stb_s2;
            ev_q   <= cmd_ev;
            if (cmd_ev) begin
                cmd_q <= CMD;
                din_q <= DIN;
            end
        end
    end

    always_ff @(posedge CLKx4 or negedge nRESET) begin
        if (!nRESET) begin
            state  <= IDLE;
            div_r  <= DIV_RESET;
            divcnt <= '0;
            bitcnt <= 3'd0;
            shreg  <= 8'h00;
            rx_bit <= 1'b0;
            SCK    <= 1'b0;
            MOSI   <= 1'b1;
            nSS    <= 2'b11;
            DOUT   <= 8'h00;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
`ifdef SPI_LSBFIRST_EN
            lsbf   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            div_r  <= div_n;
            divcnt <= divcnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            rx_bit <= rx_n;
            SCK    <= sck_n;
            MOSI   <= mosi_n;
            nSS    <= nss_n;
            DOUT   <= dout_n;
            BUSY   <= busy_n;
            ERR    <= err_n;
`ifdef SPI_LSBFIRST_EN
            lsbf   <= lsbf_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        div_n    = div_r;
        divcnt_n = divcnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        rx_n     = rx_bit;
        sck_n    = SCK;
        mosi_n   = MOSI;
        nss_n    = nSS;
        dout_n   = DOUT;
        busy_n   = BUSY;
        err_n    = ERR;
`ifdef SPI_LSBFIRST_EN
        lsbf_n   = lsbf;
`endif
        case (state)
            IDLE: begin
                if (ev_q) begin
                    case (cmd_q)
                        C_SEL: begin
                            nss_n = din_q[1:0];
                            err_n = 1'b0;
                        end
                        C_XFR: begin
                            shreg_n  = din_q;
                            mosi_n   = lsbf ? din_q[0] : din_q[7];
                            busy_n   = 1'b1;
                            bitcnt_n = 3'd0;
                            divcnt_n = div_r;
                            state_n  = LOW;
                        end
                        C_CFG: begin
                            div_n = din_q[DIVW-1:0];
`ifdef SPI_LSBFIRST_EN
                            lsbf_n = din_q[7];
`endif
                        end
                        default: ;
                    endcase
                end
            end
            LOW: begin
                if (divcnt == '0) begin
                    sck_n    = 1'b1;
                    rx_n     = misox;
                    divcnt_n = div_r;
                    state_n  = HIGH;
                end else begin
                    divcnt_n = divcnt - ONE;
                end
            end
            HIGH: begin
                if (divcnt == '0) begin
                    sck_n = 1'b0;
                    // The sample is merged on the falling edge so the outgoing bit is never overwritten early.
                    shreg_n = lsbf ? {rx_bit, shreg[7:1]} : {shreg[6:0], rx_bit};
                    if (bitcnt == 3'd7) begin
                        state_n = DONE;
                    end else begin
                        mosi_n   = lsbf ? shreg[1] : shreg[6];
                        bitcnt_n = bitcnt + 3'd1;
                        divcnt_n = div_r;
                        state_n  = LOW;
                    end
                end else begin
                    divcnt_n = divcnt - ONE;
                end
            end
            DONE: begin
                dout_n  = shreg;
                busy_n  = 1'b0;
                mosi_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && ev_q && cmd_q != C_NOP)
            err_n = 1'b1;
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Randomized bench for spi_byte_engine against a byte-level model of the SPI link.
module tb_spi_byte_engine;
    logic       CLKx4 = 1'b0;
    logic       nRESET, nSTB;
    logic [1:0] CMD;
    logic [7:0] DIN;
    logic [2:0] MISO;
    logic       MOSI, SCK, BUSY, ERR;
    logic [1:0] nSS;
    logic [7:0] DOUT;

    spi_byte_engine #(.DIVW(4), .DIV_RESET(4'd0)) dut (
        .CLKx4(CLKx4), .nRESET(nRESET), .nSTB(nSTB), .CMD(CMD), .DIN(DIN),
        .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .DOUT(DOUT),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLKx4 = ~CLKx4;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Free-running monitor; tasks take snapshots instead of clearing counters.
    int         rise_cnt = 0, busy_cnt = 0, busy_rises = 0, mosi_viol = 0, nss_viol = 0;
    int         hi_run = 0, hi_last = 0;
    logic       sck_prev = 1'b0, mosi_prev = 1'b1, busy_prev = 1'b0;
    logic [1:0] nss_prev = 2'b11;
    logic [7:0] mosi_cap = 8'h00;

    always @(negedge CLKx4) begin
        if (BUSY) busy_cnt++;
        if (BUSY && !busy_prev) busy_rises++;
        if (SCK && !sck_prev) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[6:0], MOSI};
        end
        if (SCK) hi_run++;
        else if (sck_prev) begin
            hi_last = hi_run;
            hi_run  = 0;
        end
        if (SCK && MOSI !== mosi_prev) mosi_viol++;
        if (BUSY && busy_prev && nSS !== nss_prev) nss_viol++;
        sck_prev  = SCK;
        mosi_prev = MOSI;
        busy_prev = BUSY;
        nss_prev  = nSS;
    end

    // Slave devices present their byte MSB first, advancing after each SCK rise.
    logic [7:0] dev0 = 8'h00, dev1 = 8'h00, dev2 = 8'h00;
    logic       loop2 = 1'b0;
    int         rise_base = 0;
    int         idx;
    always_comb begin
        idx = rise_cnt - rise_base;
        if (idx > 7) idx = 7;
        if (idx < 0) idx = 0;
        MISO[0] = dev0[3'(7 - idx)];
        MISO[1] = dev1[3'(7 - idx)];
        MISO[2] = loop2 ? MOSI : dev2[3'(7 - idx)];
    end

    int b_busy, b_rise, b_mv, b_nv, b_br;

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        @(negedge CLKx4);
        CMD  = c;
        DIN  = d;
        nSTB = 1'b0;
        repeat (4) @(negedge CLKx4);
        nSTB = 1'b1;
        repeat (4) @(negedge CLKx4);
    endtask

    task automatic snap();
        b_busy    = busy_cnt;
        b_rise    = rise_cnt;
        b_mv      = mosi_viol;
        b_nv      = nss_viol;
        b_br      = busy_rises;
        rise_base = rise_cnt;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (BUSY && t < 3000) begin
            @(negedge CLKx4);
            t++;
        end
        if (t >= 3000) check("busy_timeout", 32'd1, 32'd0);
        @(negedge CLKx4);
    endtask

    task automatic xfer(input logic [7:0] d);
        snap();
        send(2'b10, d);
        wait_idle();
    endtask

    // Byte-level model: the received byte is the OR of every selected source.
    function automatic logic [7:0] exp_rx(input logic [1:0] ss, input logic [7:0] d);
        logic [7:0] r, src2;
        src2 = loop2 ? d : dev2;
        r = 8'h00;
        if (!ss[0]) r |= dev0;
        if (!ss[1]) r |= dev1;
        if (ss == 2'b11) r |= src2;
        return r;
    endfunction

    task automatic check_xfer(input string tag, input int div, input logic [1:0] ss,
                              input logic [7:0] d, input logic [7:0] rx);
        check({tag, "_busy"}, busy_cnt - b_busy, 16 * (div + 1) + 1);
        check({tag, "_rises"}, rise_cnt - b_rise, 8);
        check({tag, "_mosi"}, mosi_cap, d);
        check({tag, "_dout"}, DOUT, rx);
        check({tag, "_nss"}, nSS, ss);
        check({tag, "_nssviol"}, nss_viol - b_nv, 0);
        check({tag, "_mosiviol"}, mosi_viol - b_mv, 0);
    endtask

    initial begin
        int         div, t;
        logic [1:0] ss;
        logic [7:0] d;
        nRESET = 1'b0;
        nSTB   = 1'b1;
        CMD    = 2'b00;
        DIN    = 8'h00;
        #23;
        check("rst_sck", SCK, 1'b0);
        check("rst_mosi", MOSI, 1'b1);
        check("rst_nss", nSS, 2'b11);
        check("rst_dout", DOUT, 8'h00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_err", ERR, 1'b0);
        nRESET = 1'b1;
        repeat (3) @(negedge CLKx4);

        loop2 = 1'b1;
        xfer(8'hA5);
        check_xfer("loopA5", 0, 2'b11, 8'hA5, 8'hA5);
        check("loopA5_err", ERR, 1'b0);

        loop2 = 1'b0;
        dev2  = 8'hFF;
        send(2'b11, 8'h03);
        xfer(8'h00);
        check_xfer("div3", 3, 2'b11, 8'h00, 8'hFF);
        check("div3_half", hi_last, 4);

        send(2'b01, 8'h02);
        check("sel_nss", nSS, 2'b10);
        dev0 = 8'h3C;
        dev1 = 8'h00;
        dev2 = 8'hFF;
        xfer(8'h81);
        check_xfer("dev0", 3, 2'b10, 8'h81, 8'h3C);

        snap();
        send(2'b10, 8'h12);
        check("busy_mid", BUSY, 1'b1);
        send(2'b01, 8'h01);
        send(2'b10, 8'h34);
        wait_idle();
        check("busycmd_err", ERR, 1'b1);
        check("busycmd_nss", nSS, 2'b10);
        check("busycmd_mosi", mosi_cap, 8'h12);
        repeat (40) @(negedge CLKx4);
        check("busycmd_single", busy_rises - b_br, 1);
        send(2'b00, 8'h00);
        check("nop_err", ERR, 1'b1);
        send(2'b01, 8'h03);
        check("errclr", ERR, 1'b0);
        check("errclr_nss", nSS, 2'b11);

        for (int i = 0; i < 20; i++) begin
            div = $urandom_range(0, 3);
            ss  = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            dev0  = 8'($urandom);
            dev1  = 8'($urandom);
            dev2  = 8'($urandom);
            loop2 = 1'($urandom);
            send(2'b11, 8'(div));
            send(2'b01, {6'd0, ss});
            xfer(d);
            check_xfer("rnd", div, ss, d, exp_rx(ss, d));
            check("rnd_err", ERR, 1'b0);
        end

        loop2 = 1'b1;
        send(2'b01, 8'h03);
        send(2'b11, 8'h0F);
        xfer(8'h5A);
        check_xfer("div15", 15, 2'b11, 8'h5A, 8'h5A);
        check("div15_half", hi_last, 16);

`ifdef SPI_LSBFIRST_EN
        send(2'b11, 8'h80);
        xfer(8'h01);
        check_xfer("lsbf", 0, 2'b11, 8'h80, 8'h01);
        send(2'b11, 8'h00);
`endif

        send(2'b11, 8'h01);
        send(2'b01, 8'h01);
        loop2 = 1'b0;
        dev0  = 8'hFF;
        snap();
        send(2'b10, 8'hC3);
        t = 0;
        while (rise_cnt - rise_base < 4 && t < 500) begin
            @(negedge CLKx4);
            t++;
        end
        if (t >= 500) check("rst4_timeout", 32'd1, 32'd0);
        #1 nRESET = 1'b0;
        #2;
        check("rst4_sck", SCK, 1'b0);
        check("rst4_mosi", MOSI, 1'b1);
        check("rst4_nss", nSS, 2'b11);
        check("rst4_busy", BUSY, 1'b0);
        check("rst4_dout", DOUT, 8'h00);
        repeat (2) @(negedge CLKx4);
        nRESET = 1'b1;
        repeat (200) @(negedge CLKx4);
        check("rst4_idle", BUSY, 1'b0);
        check("rst4_dout_late", DOUT, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
